// File: rtl/booth_wallace_mac_pipe_if.sv
// Handshake/data bundle for booth_wallace_mac_pipe.
//   master : beat producer / result consumer (drives in_*, out_ready)
//   slave  : the MAC unit (drives in_ready, out_*)
// Signals:
//   in_valid/in_ready      input beat handshake
//   weight, feature        signed operands, WIDTH bits
//   in_first/in_last       burst delimiters
//   out_valid/out_ready    result handshake
//   out_data               signed accumulated result, ACC_WIDTH bits
//   out_sat                saturation seen during the burst
interface booth_wallace_mac_pipe_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 40
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     weight;
  logic [WIDTH-1:0]     feature;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, weight, feature, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, weight, feature, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/booth_wallace_mac_pipe.sv
// Pipelined signed multiply-accumulate: radix-4 Booth partial products (S1),
// Wallace carry-save reduction (S2), final add + accumulate into the output
// register (S3). One dot product is emitted per first..last burst.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   mac    slave side of booth_wallace_mac_pipe_if (operands, burst flags,
//          valid/ready on input and output, result and saturation flag)
module booth_wallace_mac_pipe #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 40,
  parameter bit          SAT_EN    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  booth_wallace_mac_pipe_if.slave  mac
);
  localparam int unsigned NPP = WIDTH / 2;
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned IW  = (NPP > 1) ? $clog2(NPP) : 1;

  logic stall;

  // S1 state
  logic [PW-1:0] pp_d [NPP];
  logic [PW-1:0] pp_q [NPP];
  logic          f1_q, l1_q, v1_q;
  // S2 state
  logic [PW-1:0] sum_d, carry_d, sum_q, carry_q;
  logic          f2_q, l2_q, v2_q;
  // S3 / output state
  logic [ACC_WIDTH-1:0] acc_d, acc_q, out_data_q;
  logic                 sticky_q, out_sat_q, out_valid_q;

  assign stall         = out_valid_q & ~mac.out_ready;
  assign mac.in_ready  = ~stall;
  assign mac.out_valid = out_valid_q;
  assign mac.out_data  = out_data_q;
  assign mac.out_sat   = out_sat_q;

  // ---------------- S1: radix-4 Booth partial products ----------------
  // All arithmetic is modulo 2^PW; the exact product always fits in PW
  // signed bits, so plain two's-complement negation needs no correction row.
  logic [WIDTH:0]  b_ext;
  logic [PW-1:0]   a_ext;

  always_comb begin
    b_ext = {mac.feature, 1'b0};
    a_ext = PW'($signed(mac.weight));
    for (int unsigned i = 0; i < NPP; i++) begin
      unique case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp_d[i] = a_ext << (2*i);
        3'b011:         pp_d[i] = a_ext << (2*i + 1);
        3'b100:         pp_d[i] = (-a_ext) << (2*i + 1);
        3'b101, 3'b110: pp_d[i] = (-a_ext) << (2*i);
        default:        pp_d[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_q <= '{default: '0};
      f1_q <= 1'b0;
      l1_q <= 1'b0;
      v1_q <= 1'b0;
    end else if (!stall) begin
      v1_q <= mac.in_valid;
      if (mac.in_valid) begin
        pp_q <= pp_d;
        f1_q <= mac.in_first;
        l1_q <= mac.in_last;
      end
    end
  end

  // ---------------- S2: Wallace reduction to sum/carry ----------------
  // Each level compresses every full group of three rows with a 3:2 CSA and
  // passes leftover rows through; the row counts depend only on NPP.
  logic [PW-1:0] row [NPP];
  logic [PW-1:0] nxt [NPP];
  int unsigned   cnt, ncnt, full;

  always_comb begin
    row  = pp_q;
    nxt  = pp_q;
    cnt  = NPP;
    ncnt = 0;
    full = 0;
    for (int unsigned l = 0; l < NPP; l++) begin
      if (cnt > 2) begin
        nxt  = row;
        ncnt = 0;
        full = cnt / 3;
        for (int unsigned g = 0; g < NPP / 3; g++) begin
          if (g < full) begin
            nxt[ncnt[IW-1:0]] = row[3*g] ^ row[3*g+1] ^ row[3*g+2];
            ncnt = ncnt + 1;
            nxt[ncnt[IW-1:0]] = ((row[3*g] & row[3*g+1]) |
                                 (row[3*g] & row[3*g+2]) |
                                 (row[3*g+1] & row[3*g+2])) << 1;
            ncnt = ncnt + 1;
          end
        end
        for (int unsigned j = 0; j < NPP; j++) begin
          if ((j >= 3 * full) && (j < cnt)) begin
            nxt[ncnt[IW-1:0]] = row[j];
            ncnt = ncnt + 1;
          end
        end
        row = nxt;
        cnt = ncnt;
      end
    end
    sum_d   = row[0];
    carry_d = (cnt > 1) ? row[1] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      f2_q    <= 1'b0;
      l2_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else if (!stall) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        f2_q    <= f1_q;
        l2_q    <= l1_q;
      end
    end
  end

  // ---------------- S3: final add, accumulate, saturate ----------------
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext, base;
  logic [ACC_WIDTH:0]   wide;
  logic                 ovf, sticky_base;

  always_comb begin
    prod        = sum_q + carry_q;
    prod_ext    = ACC_WIDTH'($signed(prod));
    base        = f2_q ? '0 : acc_q;
    sticky_base = ~f2_q & sticky_q;
    // One guard bit: overflow shows up as the two top bits disagreeing.
    wide        = {base[ACC_WIDTH-1], base} + {prod_ext[ACC_WIDTH-1], prod_ext};
    ovf         = 1'b0;
    acc_d       = wide[ACC_WIDTH-1:0];
    if (SAT_EN && (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])) begin
      ovf   = 1'b1;
      acc_d = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  // out_valid simply follows "last beat in S3" whenever not stalled: when not
  // stalled any held result is being consumed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= v2_q & l2_q;
      if (v2_q) begin
        if (l2_q) begin
          out_data_q <= acc_d;
          out_sat_q  <= sticky_base | ovf;
          acc_q      <= '0;
          sticky_q   <= 1'b0;
        end else begin
          acc_q    <= acc_d;
          sticky_q <= sticky_base | ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_wallace_mac_pipe.sv
// Self-checking bench for booth_wallace_mac_pipe. Two instances share one
// stimulus stream: a wrapping 40-bit unit and a saturating 32-bit unit.
module tb_booth_wallace_mac_pipe;
  localparam int unsigned W = 16;
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [W-1:0] weight = '0, feature = '0;
  logic         ready_dir = 1'b1, rnd_ready = 1'b1, throttle = 1'b0;
  logic         out_ready;
  assign out_ready = throttle ? rnd_ready : ready_dir;

  booth_wallace_mac_pipe_if #(.WIDTH(W), .ACC_WIDTH(40)) if0 ();
  booth_wallace_mac_pipe_if #(.WIDTH(W), .ACC_WIDTH(32)) if1 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_first = in_first;  assign if1.in_first = in_first;
  assign if0.in_last  = in_last;   assign if1.in_last  = in_last;
  assign if0.weight   = weight;    assign if1.weight   = weight;
  assign if0.feature  = feature;   assign if1.feature  = feature;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  booth_wallace_mac_pipe #(.WIDTH(W), .ACC_WIDTH(40), .SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mac(if0.slave));
  booth_wallace_mac_pipe #(.WIDTH(W), .ACC_WIDTH(32), .SAT_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mac(if1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  longint acc0 = 0, acc1 = 0;
  bit     stk1 = 1'b0;
  longint q0[$];
  longint q1d[$];
  bit     q1s[$];
  longint p, s0, s1;
  bit     st;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.out_valid && out_ready) begin
        if (q0.size() == 0) check("dut0_unexpected_result", 1, 0);
        else check("dut0_data", longint'($signed(if0.out_data)), q0.pop_front());
        check("dut0_sat", longint'(if0.out_sat), 0);
      end
      if (if1.out_valid && out_ready) begin
        if (q1d.size() == 0) check("dut1_unexpected_result", 1, 0);
        else begin
          check("dut1_data", longint'($signed(if1.out_data)), q1d.pop_front());
          check("dut1_sat", longint'(if1.out_sat), longint'(q1s.pop_front()));
        end
      end
      if (in_valid && if0.in_ready) begin
        p  = longint'($signed(weight)) * longint'($signed(feature));
        s0 = (in_first ? 64'sd0 : acc0) + p;
        s0 = (s0 <<< 24) >>> 24;
        s1 = (in_first ? 64'sd0 : acc1) + p;
        st = in_first ? 1'b0 : stk1;
        if (s1 > MAX32) begin s1 = MAX32; st = 1'b1; end
        else if (s1 < MIN32) begin s1 = MIN32; st = 1'b1; end
        if (in_last) begin
          q0.push_back(s0); q1d.push_back(s1); q1s.push_back(st);
          acc0 = 0; acc1 = 0; stk1 = 1'b0;
        end else begin
          acc0 = s0; acc1 = s1; stk1 = st;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_beat(input logic [W-1:0] w, input logic [W-1:0] f,
                           input bit fi, input bit la);
    int unsigned n = 0;
    in_valid = 1'b1; weight = w; feature = f; in_first = fi; in_last = la;
    do begin @(negedge clk); n++; end while (!if0.in_ready && n < 300);
    if (!if0.in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result(input string tag, input longint e0, input longint e1,
                             input bit es1);
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (!if0.out_valid && n < 100);
    check({tag, "_valid"}, longint'(if0.out_valid), 1);
    check({tag, "_latency"}, longint'(n), 3);
    check({tag, "_data0"}, longint'($signed(if0.out_data)), e0);
    check({tag, "_data1"}, longint'($signed(if1.out_data)), e1);
    check({tag, "_sat1"}, longint'(if1.out_sat), longint'(es1));
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned len, n;
    bit nofirst;
    logic [W-1:0] w, f;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(if0.out_valid), 0);
    check("rst_out_data", longint'(if0.out_data), 0);
    check("rst_out_sat1", longint'(if1.out_sat), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", longint'(if0.in_ready), 1);

    // most-negative squared, single-beat burst
    ready_dir = 1'b1;
    send_beat(16'h8000, 16'h8000, 1'b1, 1'b1);
    wait_result("t1_minneg", 64'sd1073741824, 64'sd1073741824, 1'b0);

    // four-beat burst back to back
    send_beat(16'sd3, 16'sd5, 1'b1, 1'b0);
    send_beat(-16'sd7, 16'sd2, 1'b0, 1'b0);
    send_beat(16'sd100, -16'sd100, 1'b0, 1'b0);
    send_beat(16'sd1, 16'sd1, 1'b0, 1'b1);
    wait_result("t2_burst", -64'sd9998, -64'sd9998, 1'b0);

    // backpressure: results held while out_ready is low
    ready_dir = 1'b0;
    send_beat(16'sd2, 16'sd3, 1'b1, 1'b1);
    send_beat(-16'sd4, 16'sd4, 1'b1, 1'b1);
    n = 0;
    while (!if0.out_valid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      check("t3_in_ready_low", longint'(if0.in_ready), 0);
      check("t3_hold_data", longint'($signed(if0.out_data)), 6);
      @(negedge clk);
    end
    @(posedge clk); #1;
    ready_dir = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_second_valid", longint'(if0.out_valid), 1);
    check("t3_second_data", longint'($signed(if0.out_data)), -16);
    @(posedge clk); #1;

    // saturation on the 32-bit instance, sticky flag, then clean burst
    for (int k = 0; k < 3; k++) send_beat(16'h8000, 16'h8000, k == 0, k == 2);
    wait_result("t4_sat", 64'sd3221225472, MAX32, 1'b1);
    send_beat(16'sd1, 16'sd1, 1'b1, 1'b1);
    wait_result("t4_after", 1, 1, 1'b0);

    // random bursts, gaps and output throttling
    throttle = 1'b1;
    for (int b = 0; b < 40; b++) begin
      len = $urandom_range(1, 64);
      nofirst = ($urandom_range(0, 3) == 0);
      for (int unsigned k = 0; k < len; k++) begin
        w = W'($urandom); f = W'($urandom);
        if ($urandom_range(0, 7) == 0) w = 16'h8000;
        if ($urandom_range(0, 7) == 0) f = 16'h8000;
        send_beat(w, f, (k == 0) && !nofirst, k == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    throttle = 1'b0;
    ready_dir = 1'b1;
    n = 0;
    while ((q0.size() != 0 || q1d.size() != 0) && n < 300) begin @(posedge clk); n++; end
    #1;
    check("rand_drain0", longint'(q0.size()), 0);
    check("rand_drain1", longint'(q1d.size()), 0);

    // reset mid-burst while stalled
    ready_dir = 1'b0;
    send_beat(16'sd2, 16'sd2, 1'b1, 1'b1);
    send_beat(16'sd3, 16'sd3, 1'b1, 1'b0);
    send_beat(16'sd4, 16'sd4, 1'b0, 1'b0);
    in_valid = 1'b1; weight = 16'sd9; feature = 16'sd9;
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", longint'(if0.out_valid), 0);
    check("t6_rst_data0", longint'(if0.out_data), 0);
    check("t6_rst_data1", longint'(if1.out_data), 0);
    check("t6_rst_sat1", longint'(if1.out_sat), 0);
    in_valid = 1'b0;
    q0.delete(); q1d.delete(); q1s.delete();
    acc0 = 0; acc1 = 0; stk1 = 1'b0;
    ready_dir = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'sd5, 16'sd5, 1'b0, 1'b1);
    wait_result("t6_fresh", 25, 25, 1'b0);
    idle(4);
    check("final_drain", longint'(q0.size() + q1d.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/booth_wallace_mac_pipe.md
Name: booth_wallace_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the conv1d datapath.
- Structure: radix-4 Booth encoding, then a Wallace carry-save tree, then a final adder and accumulator.
- Each stage is registered, and the pipeline has a valid/ready handshake on both sides.
- Accumulates a burst of weight×feature products delimited by first/last flags and emits one dot-product result per burst. It replaces the single-cycle combinational multiplier in the conv1d PE.

Parameters:
- WIDTH, 16, operand width in bits; two's complement; must be even and ≥4.
- ACC_WIDTH, 40, accumulator/result width; must be ≥ 2*WIDTH.
- SAT_EN, 0, 1 = saturate the accumulator at the signed ACC_WIDTH limits; 0 = two's-complement wrap.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- weight  input  WIDTH  signed multiplicand.
- feature  input  WIDTH  signed multiplier.
- in_first  input  1  beat starts a new accumulation (accumulator is discarded).
- in_last  input  1  beat ends the accumulation; its result is emitted.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_WIDTH  accumulated signed result.
- out_sat  output  1  saturation occurred during this burst (always 0 when SAT_EN=0).

Behaviour:
- Reset is asynchronous, active-low, and applies to all registers:
  - out_valid=0, out_data=0, out_sat=0, accumulator=0, sticky saturation flag=0, all stage valid bits=0.
  - in_ready=1 once reset is released.
- Stall and handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stall is high, every pipeline register (data and valid) holds.
  - A beat is accepted when in_valid & in_ready.
- S1 (Booth):
  - Registers WIDTH/2 partial products, each sign-extended to 2*WIDTH, together with first/last and valid.
  - Booth digits use the usual {b[2i+1], b[2i], b[2i-1]} grouping with b[-1]=0.
- S2 (Wallace):
  - Reduces the partial products to a sum/carry pair, each 2*WIDTH wide; carry is pre-shifted left by 1.
  - Registers sum, carry, flags and valid.
- S3 (accumulate):
  - product = sum + carry, truncated to 2*WIDTH bits, then sign-extended to ACC_WIDTH.
  - acc_next = product if first, else acc + product.
  - With SAT_EN=1, the add is done at ACC_WIDTH+1 bits. On overflow, acc_next is clamped to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and the sticky flag is set.
  - The sticky flag clears on a first beat.
- On a valid S3 beat with last:
  - out_data ← acc_next, out_sat ← sticky | this-beat overflow, out_valid ← 1.
  - The accumulator and sticky flag clear to 0.
- On a valid S3 beat without last: the accumulator takes acc_next; the output is unchanged.
- Latency: 3 cycles from the accepted last beat to out_valid=1, with no stall.
- Throughput: 1 beat/cycle.
- out_valid falls after out_valid & out_ready, unless a new last beat reaches S3 in that same cycle. In that case out_valid stays 1 and out_data updates with no bubble.
- first and last on the same beat: single-product result.
- Beat without first after a last: it accumulates onto 0, which is legal.
- Bubbles (in_valid=0) between beats of one burst: allowed; the accumulator holds.
- Most-negative operand (-2^(WIDTH-1)) on either or both inputs must produce the exact product.
- Reset mid-burst or mid-stall: everything is discarded, with no partial output.

Test Plan:
- WIDTH=16, single beat with first=last=1, weight=-32768, feature=-32768 → after 3 cycles out_valid=1, out_data=1073741824, out_sat=0.
- Burst of 4 beats, pairs (3,5), (-7,2), (100,-100), (1,1), back-to-back with out_ready=1 → one result, out_data=-9998, exactly 3 cycles after the last beat.
- Two back-to-back single-beat bursts, (2,3) then (-4,4), with out_ready held 0 for 5 cycles → in_ready=0 from the cycle after the first result. The first result, 6, holds stable; after out_ready=1 the next result, -16, follows with no data loss.
- SAT_EN=1, ACC_WIDTH=32, burst of 3 beats of (-32768,-32768) → out_data=2147483647, out_sat=1. The next burst (1,1) → out_data=1, out_sat=0.
- Random signed operands, random burst lengths 1–64, random in_valid gaps and out_ready throttling (SAT_EN=0) → every result matches the scoreboard, computed wrapped to ACC_WIDTH.
- Assert rst_n mid-burst during a stall → all outputs 0 immediately. A fresh burst (5,5) afterwards → out_data=25, with no residue from before reset.
